// File: rtl/ysyx_220066_dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, memory-op codes,
// the latched request payload and the byte-merge helper used by the storage array.
package ysyx_220066_dmem_resp_pkg;

    localparam int unsigned DM_STATE_W = 2;

    localparam logic [DM_STATE_W-1:0] DM_IDLE = 2'd0;
    localparam logic [DM_STATE_W-1:0] DM_WAIT = 2'd1;
    localparam logic [DM_STATE_W-1:0] DM_RESP = 2'd2;

    // Load/store op codes, shared with the core's lane-select and sign-extension logic.
    typedef enum logic [3:0] {
        MEMOP_LB  = 4'd0,
        MEMOP_LH  = 4'd1,
        MEMOP_LW  = 4'd2,
        MEMOP_LD  = 4'd3,
        MEMOP_LBU = 4'd4,
        MEMOP_LHU = 4'd5,
        MEMOP_LWU = 4'd6,
        MEMOP_SB  = 4'd7,
        MEMOP_SH  = 4'd8,
        MEMOP_SW  = 4'd9,
        MEMOP_SD  = 4'd10
    } memop_e;

    typedef struct packed {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } dm_req_t;

    // Replace only the enabled bytes of old_w with the matching bytes of new_w.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_w,
                                               input logic [63:0] new_w,
                                               input logic [7:0]  be);
        logic [63:0] m;
        m = old_w;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/ysyx_220066_sram64.sv
// DEPTH x 64-bit storage with one synchronous port: byte-enabled write and a
// registered read word. Contents are intentionally not reset.
module ysyx_220066_sram64
    import ysyx_220066_dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [7:0]       i_be,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [63:0]      i_wdata,
    output logic [63:0]      o_rdata
);

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) r_mem[i_idx] <= byte_merge(r_mem[i_idx], i_wdata, i_be);
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_220066_dmem_resp.sv
// Data-memory responder: accepts one aligned read or byte-masked write per handshake
// and answers exactly LATENCY cycles later with the raw 64-bit word and a range error.
module ysyx_220066_dmem_resp
    import ysyx_220066_dmem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] BASE_LO = BASE[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   SPAN    = (ADDR_W+1)'(DEPTH * 8);

    logic [DM_STATE_W-1:0] r_state;
    logic [DM_STATE_W-1:0] w_state_nx;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nx;
    dm_req_t               r_req;

    logic r_req_ready;
    logic r_resp_valid;
    logic r_resp_err;
    logic r_rd_ok;

    logic              w_accept;
    logic              w_access;
    logic              w_handshake;
    logic              w_in_range;
    logic              w_sram_en;
    logic [ADDR_W-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [63:0]       w_sram_rdata;
    logic              w_unused;

    // Next-state logic; the storage access fires in the last WAIT cycle.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            DM_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = DM_WAIT;
                    w_cnt_nx   = CNT_W'(LATENCY - 1);
                end
            end
            DM_WAIT: begin
                if (r_cnt == '0) begin
                    w_access   = 1'b1;
                    w_state_nx = DM_RESP;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            DM_RESP: begin
                if (resp_ready) begin
                    w_handshake = 1'b1;
                    w_state_nx  = DM_IDLE;
                end
            end
            default: w_state_nx = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DM_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Handshake flags track the next state so they line up with it after each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_ok      <= 1'b0;
        end else begin
            r_req_ready  <= (w_state_nx == DM_IDLE);
            r_resp_valid <= (w_state_nx == DM_RESP);
            if (w_access) begin
                r_resp_err <= !w_in_range;
                r_rd_ok    <= w_in_range && !r_req.wr;
            end else if (w_handshake) begin
                r_resp_err <= 1'b0;
                r_rd_ok    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_req.wr    <= req_wr;
            r_req.addr  <= req_addr;
            r_req.wdata <= req_wdata;
            r_req.wmask <= req_wmask;
        end
    end

    // Offset from BASE within the decoded address bits; the low three bits never matter.
    assign w_off      = r_req.addr[ADDR_W-1:0] - BASE_LO;
    assign w_in_range = (r_req.addr[ADDR_W-1:0] >= BASE_LO) && ({1'b0, w_off} < SPAN);
    assign w_idx      = w_off[IDX_W+2:3];
    assign w_sram_en  = w_access && w_in_range && !rst;
    assign w_unused   = ^r_req.addr[63:ADDR_W];

    ysyx_220066_sram64 #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_sram_en),
        .i_we    (r_req.wr),
        .i_be    (r_req.wmask),
        .i_idx   (w_idx),
        .i_wdata (r_req.wdata),
        .o_rdata (w_sram_rdata)
    );

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_rd_ok ? w_sram_rdata : 64'h0;

endmodule
